// File: rtl/cu_mac_sequencer.sv
// Sequencer that time-multiplexes one external computer unit through a
// multiply/accumulate loop followed by bias subtraction and threshold compare.
module cu_mac_sequencer #(
    parameter int unsigned DW    = 32,
    parameter int unsigned CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [CNT_W-1:0] len,
    input  logic [DW-1:0]    bias,
    input  logic [DW-1:0]    threshold,
    input  logic             in_valid,
    input  logic [DW-1:0]    in_data,
    input  logic [DW-1:0]    in_par,
    output logic             in_ready,
    output logic             cu_enable,
    output logic [1:0]       cu_sel,
    output logic [DW-1:0]    cu_data,
    output logic [DW-1:0]    cu_par,
    input  logic [DW-1:0]    cu_out,
    output logic             busy,
    output logic             out_valid,
    output logic [DW-1:0]    out_result,
    output logic             out_flag,
    input  logic             out_ready
);

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_MUL   = 3'd1;
    localparam logic [2:0] S_ADD   = 3'd2;
    localparam logic [2:0] S_DRAIN = 3'd3;
    localparam logic [2:0] S_BIAS  = 3'd4;
    localparam logic [2:0] S_CMP   = 3'd5;
    localparam logic [2:0] S_DONE  = 3'd6;

    localparam logic [1:0] SEL_SUB = 2'b00;
    localparam logic [1:0] SEL_CMP = 2'b01;
    localparam logic [1:0] SEL_ADD = 2'b10;
    localparam logic [1:0] SEL_MUL = 2'b11;

    logic [2:0]       state_q,   state_d;
    logic [CNT_W-1:0] count_q,   count_d;
    logic [CNT_W-1:0] len_q,     len_d;
    logic [DW-1:0]    bias_q,    bias_d;
    logic [DW-1:0]    thr_q,     thr_d;
    logic [DW-1:0]    acc_q,     acc_d;
    logic             pending_q, pending_d;
    logic [DW-1:0]    result_q,  result_d;
    logic             flag_q,    flag_d;

    always_comb begin
        state_d   = state_q;
        count_d   = count_q;
        len_d     = len_q;
        bias_d    = bias_q;
        thr_d     = thr_q;
        acc_d     = acc_q;
        pending_d = pending_q;
        result_d  = result_q;
        flag_d    = flag_q;
        in_ready  = 1'b0;
        cu_enable = 1'b0;
        cu_sel    = SEL_SUB;
        cu_data   = '0;
        cu_par    = '0;

        // The sum issued by the previous ADD is visible on cu_out now.
        if (pending_q) begin
            acc_d     = cu_out;
            pending_d = 1'b0;
        end

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    len_d     = len;
                    bias_d    = bias;
                    thr_d     = threshold;
                    acc_d     = '0;
                    count_d   = '0;
                    pending_d = 1'b0;
                    state_d   = (len != '0) ? S_MUL : S_DRAIN;
                end
            end
            S_MUL: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    cu_enable = 1'b1;
                    cu_sel    = SEL_MUL;
                    cu_data   = in_data;
                    cu_par    = in_par;
                    count_d   = count_q + 1'b1;
                    state_d   = S_ADD;
                end
            end
            S_ADD: begin
                cu_enable = 1'b1;
                cu_sel    = SEL_ADD;
                cu_data   = acc_q;
                cu_par    = cu_out;
                pending_d = 1'b1;
                state_d   = (count_q < len_q) ? S_MUL : S_DRAIN;
            end
            S_DRAIN: begin
                state_d = S_BIAS;
            end
            S_BIAS: begin
                cu_enable = 1'b1;
                cu_sel    = SEL_SUB;
                cu_data   = acc_q;
                cu_par    = bias_q;
                state_d   = S_CMP;
            end
            S_CMP: begin
                cu_enable = 1'b1;
                cu_sel    = SEL_CMP;
                cu_data   = cu_out;
                cu_par    = thr_q;
                result_d  = cu_out;
                state_d   = S_DONE;
            end
            S_DONE: begin
                flag_d = cu_out[0];
                if (out_ready) begin
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= S_IDLE;
            count_q   <= '0;
            len_q     <= '0;
            bias_q    <= '0;
            thr_q     <= '0;
            acc_q     <= '0;
            pending_q <= 1'b0;
            result_q  <= '0;
            flag_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            count_q   <= count_d;
            len_q     <= len_d;
            bias_q    <= bias_d;
            thr_q     <= thr_d;
            acc_q     <= acc_d;
            pending_q <= pending_d;
            result_q  <= result_d;
            flag_q    <= flag_d;
        end
    end

    // The compare result only reaches cu_out in the first DONE cycle; the CU
    // holds it throughout DONE, so the flag bypasses flag_q while there.
    assign out_flag   = (state_q == S_DONE) ? cu_out[0] : flag_q;
    assign out_valid  = (state_q == S_DONE);
    assign busy       = (state_q != S_IDLE);
    assign out_result = result_q;

endmodule

// File: tb/tb_cu_mac_sequencer.sv
// Directed bench for cu_mac_sequencer with a behavioural CU model attached.
module tb_cu_mac_sequencer;

    localparam int DW    = 32;
    localparam int CNT_W = 8;

    logic             clk;
    logic             rst_n;
    logic             start;
    logic [CNT_W-1:0] len;
    logic [DW-1:0]    bias;
    logic [DW-1:0]    threshold;
    logic             in_valid;
    logic [DW-1:0]    in_data;
    logic [DW-1:0]    in_par;
    logic             in_ready;
    logic             cu_enable;
    logic [1:0]       cu_sel;
    logic [DW-1:0]    cu_data;
    logic [DW-1:0]    cu_par;
    logic [DW-1:0]    cu_out;
    logic             busy;
    logic             out_valid;
    logic [DW-1:0]    out_result;
    logic             out_flag;
    logic             out_ready;

    cu_mac_sequencer #(.DW(DW), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .len(len), .bias(bias),
        .threshold(threshold), .in_valid(in_valid), .in_data(in_data),
        .in_par(in_par), .in_ready(in_ready), .cu_enable(cu_enable),
        .cu_sel(cu_sel), .cu_data(cu_data), .cu_par(cu_par), .cu_out(cu_out),
        .busy(busy), .out_valid(out_valid), .out_result(out_result),
        .out_flag(out_flag), .out_ready(out_ready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Computer unit: registered, one-cycle latency, holds while disabled.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) cu_out <= '0;
        else if (cu_enable) begin
            case (cu_sel)
                2'b00: cu_out <= cu_data - cu_par;
                2'b01: cu_out <= {31'd0, (cu_data > cu_par)};
                2'b10: cu_out <= cu_data + cu_par;
                default: cu_out <= cu_data * cu_par;
            endcase
        end
    end

    typedef struct packed {
        logic [7:0]       len;
        logic [31:0]      bias;
        logic [31:0]      thr;
        logic [3:0][31:0] d;
        logic [3:0][31:0] p;
        logic [3:0][3:0]  stall;
        logic [31:0]      exp_res;
        logic             exp_flag;
        logic [7:0]       exp_lat;
    } vec_t;

    vec_t       vecs[6];
    int         checks = 0;
    int         errors = 0;
    logic [1:0] sel_log[16];
    int         sel_n;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic vec_t mk(input logic [7:0] l, input logic [31:0] b, input logic [31:0] t,
                                input logic [3:0][31:0] d, input logic [3:0][31:0] p,
                                input logic [3:0][3:0] s, input logic [31:0] er,
                                input logic ef, input logic [7:0] el);
        vec_t v;
        v.len = l; v.bias = b; v.thr = t; v.d = d; v.p = p; v.stall = s;
        v.exp_res = er; v.exp_flag = ef; v.exp_lat = el;
        return v;
    endfunction

    // Starts a job, feeds its pairs (with optional stalls before each pair) and
    // returns once out_valid is seen, at the negedge of the first DONE cycle.
    task automatic run_job(input vec_t v, output int lat, output logic [31:0] res,
                           output logic flg, output logic saw_ready);
        int  idx;
        int  st;
        int  cyc;
        bit  got;
        bit  took;
        idx = 0; st = 0; cyc = 0; got = 0; sel_n = 0; saw_ready = 0;
        res = '0; flg = 1'b0;
        @(posedge clk); #1;
        start = 1'b1; len = v.len; bias = v.bias; threshold = v.thr; out_ready = 1'b0;
        @(posedge clk); #1;
        start = 1'b0; cyc = 1;
        while (cyc < 200 && !got) begin
            in_valid = 1'b0;
            if (in_ready && idx < int'(v.len)) begin
                if (st < int'(v.stall[idx])) st++;
                else begin
                    in_valid = 1'b1; in_data = v.d[idx]; in_par = v.p[idx];
                end
            end
            @(negedge clk);
            took = in_valid && in_ready;
            if (in_ready) saw_ready = 1'b1;
            if (cu_enable && sel_n < 16) begin
                sel_log[sel_n] = cu_sel;
                sel_n++;
            end
            if (out_valid) begin
                got = 1; res = out_result; flg = out_flag;
            end else begin
                @(posedge clk);
                if (took) begin idx++; st = 0; end
                #1; cyc++;
            end
        end
        in_valid = 1'b0;
        lat = cyc;
        if (!got) check("job_timeout", 32'(cyc), 32'(v.exp_lat));
    endtask

    task automatic finish_job(input string name);
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        @(negedge clk);
        check({name, "_valid_drop"}, {31'd0, out_valid}, 32'd0);
        check({name, "_busy_drop"},  {31'd0, busy},      32'd0);
    endtask

    initial begin
        int          lat;
        logic [31:0] res;
        logic        flg;
        logic        sr;
        logic [1:0]  exp_sel[8];

        rst_n = 1'b0; start = 1'b0; len = '0; bias = '0; threshold = '0;
        in_valid = 1'b0; in_data = '0; in_par = '0; out_ready = 1'b0;

        vecs[0] = mk(8'd3, 32'd10, 32'd20, {32'd0, 32'd3, 32'd2, 32'd1},
                     {32'd0, 32'd6, 32'd5, 32'd4}, 16'h0000, 32'd22, 1'b1, 8'd10);
        vecs[1] = mk(8'd3, 32'd10, 32'd22, {32'd0, 32'd3, 32'd2, 32'd1},
                     {32'd0, 32'd6, 32'd5, 32'd4}, 16'h0000, 32'd22, 1'b0, 8'd10);
        vecs[2] = mk(8'd0, 32'd5, 32'd0, '0, '0, 16'h0000, 32'hFFFF_FFFB, 1'b1, 8'd4);
        vecs[3] = mk(8'd2, 32'd0, 32'd0, {64'd0, 32'd3, 32'h0001_0000},
                     {64'd0, 32'd3, 32'h0001_0000}, 16'h0030, 32'd9, 1'b1, 8'd11);
        vecs[4] = mk(8'd1, 32'd2, 32'd39, {96'd0, 32'd7}, {96'd0, 32'd6},
                     16'h0000, 32'd40, 1'b1, 8'd6);
        vecs[5] = mk(8'd2, 32'd0, 32'd0, {64'd0, 32'd1, 32'hFFFF_FFFF},
                     {64'd0, 32'd1, 32'd1}, 16'h0000, 32'd0, 1'b0, 8'd8);

        exp_sel = '{2'b11, 2'b10, 2'b11, 2'b10, 2'b11, 2'b10, 2'b00, 2'b01};

        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_busy",      {31'd0, busy},      32'd0);
        check("rst_in_ready",  {31'd0, in_ready},  32'd0);
        check("rst_out_valid", {31'd0, out_valid}, 32'd0);
        check("rst_cu_enable", {31'd0, cu_enable}, 32'd0);
        check("rst_cu_sel",    {30'd0, cu_sel},    32'd0);
        check("rst_out_result", out_result,        32'd0);
        check("rst_out_flag",  {31'd0, out_flag},  32'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;

        for (int i = 0; i < 6; i++) begin
            run_job(vecs[i], lat, res, flg, sr);
            check($sformatf("v%0d_latency", i), 32'(lat), 32'(vecs[i].exp_lat));
            check($sformatf("v%0d_result", i),  res, vecs[i].exp_res);
            check($sformatf("v%0d_flag", i),    {31'd0, flg}, {31'd0, vecs[i].exp_flag});
            check($sformatf("v%0d_in_ready_seen", i), {31'd0, sr},
                  {31'd0, (vecs[i].len != 8'd0)});
            if (i == 0) begin
                check("v0_sel_count", 32'(sel_n), 32'd8);
                for (int k = 0; k < 8; k++)
                    check($sformatf("v0_sel%0d", k), {30'd0, sel_log[k]}, {30'd0, exp_sel[k]});
            end
            finish_job($sformatf("v%0d", i));
        end

        // Backpressure in DONE with start pulsed; outputs must hold.
        run_job(vecs[0], lat, res, flg, sr);
        check("bp_latency", 32'(lat), 32'd10);
        for (int k = 0; k < 5; k++) begin
            @(posedge clk); #1;
            start = (k == 2); len = 8'd1; bias = 32'd99;
            @(negedge clk);
            check($sformatf("bp%0d_hold", k),
                  {29'd0, out_valid, busy, out_flag}, {29'd0, 3'b111});
            check($sformatf("bp%0d_result", k), out_result, 32'd22);
        end
        start = 1'b0;
        finish_job("bp");
        run_job(vecs[2], lat, res, flg, sr);
        check("bp_next_latency", 32'(lat), 32'd4);
        check("bp_next_result", res, 32'hFFFF_FFFB);
        finish_job("bp_next");

        // Asynchronous reset in the ADD cycle of a len=4 job.
        @(posedge clk); #1;
        start = 1'b1; len = 8'd4; bias = 32'd0; threshold = 32'd0;
        in_valid = 1'b1; in_data = 32'd5; in_par = 32'd7;
        @(posedge clk); #1;
        start = 1'b0;
        @(posedge clk); #1;
        in_valid = 1'b0;
        check("ar_in_add_sel", {30'd0, cu_sel}, 32'd2);
        check("ar_in_add_par", cu_par, 32'd35);
        #1 rst_n = 1'b0;
        #1;
        check("ar_busy",      {31'd0, busy},      32'd0);
        check("ar_in_ready",  {31'd0, in_ready},  32'd0);
        check("ar_out_valid", {31'd0, out_valid}, 32'd0);
        check("ar_cu_enable", {31'd0, cu_enable}, 32'd0);
        check("ar_cu_sel",    {30'd0, cu_sel},    32'd0);
        check("ar_cu_data",   cu_data,            32'd0);
        check("ar_cu_par",    cu_par,             32'd0);
        check("ar_out_result", out_result,        32'd0);
        check("ar_out_flag",  {31'd0, out_flag},  32'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        run_job(vecs[0], lat, res, flg, sr);
        check("ar_next_latency", 32'(lat), 32'd10);
        check("ar_next_result", res, 32'd22);
        check("ar_next_flag", {31'd0, flg}, 32'd1);
        finish_job("ar_next");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/cu_mac_sequencer.md
Name: cu_mac_sequencer

Overview:
- Controller that time-multiplexes one computer_unit (CU) into a dot-product / bias / threshold sequence for a PE.
- Accepts a job (length, bias, threshold), streams N (data, weight) pairs over valid/ready and issues MUL and ADD ops to the CU.
- Then issues SUB (bias) and CMP (threshold) and returns the 32-bit result plus a 1-bit activation flag on a valid/ready output.
- Sits between the PE operand buffers and its CU; owns every CU control input.

Parameters:
DW, 32, datapath width; matches CU width
CNT_W, 8, width of job length; max N = 2^CNT_W-1

Ports:
clk  in  1  clock, rising edge
rst_n  in  1  asynchronous active-low reset
start  in  1  job start pulse; sampled only in IDLE
len  in  CNT_W  number of pairs N; latched on accepted start
bias  in  DW  subtrahend; latched on accepted start
threshold  in  DW  compare operand; latched on accepted start
in_valid  in  1  operand pair valid
in_data  in  DW  input activation
in_par  in  DW  weight
in_ready  out  1  pair accepted when in_valid & in_ready
cu_enable  out  1  CU enable; high only in issue cycles
cu_sel  out  2  CU op: 00 SUB, 01 CMP, 10 ADD, 11 MUL
cu_data  out  DW  CU Input_data
cu_par  out  DW  CU Input_par
cu_out  in  DW  CU Out (registered, 1-cycle latency)
busy  out  1  high whenever state != IDLE
out_valid  out  1  result valid
out_result  out  DW  acc - bias, mod 2^DW
out_flag  out  1  (acc - bias) > threshold, unsigned
out_ready  in  1  result consumed when out_valid & out_ready

Behaviour:
- Reset (async, rst_n=0): state IDLE; busy, in_ready, out_valid, cu_enable, out_flag = 0; cu_sel = 2'b00; cu_data, cu_par, out_result, acc, count = 0; pending = 0. Reset mid-job aborts the job; no partial result is presented.
- CU contract: cu_* are combinational from state and registers. The CU samples them at the rising edge ending the issue cycle, and cu_out holds the result in the following cycle. The CU holds cu_out while cu_enable = 0.
- States: IDLE, MUL, ADD, DRAIN, BIAS, CMP, DONE.
- IDLE: when start=1, latch len/bias/threshold, clear acc, count and pending. Go to MUL if len != 0, else DRAIN. start in any other state is ignored.
- MUL: in_ready = 1. When in_valid = 1, drive cu_enable = 1, cu_sel = 11, cu_data = in_data, cu_par = in_par, count++, and go to ADD. When in_valid = 0, cu_enable = 0 and stay (stall; cu_out preserved).
- ADD: in_ready = 0. Drive cu_enable = 1, cu_sel = 10, cu_data = acc, cu_par = cu_out (the product), and set pending. Go to MUL if count < len, else DRAIN.
- pending: in any cycle with pending = 1, acc <= cu_out and pending clears. Exception: if that cycle is itself an ADD issue, pending stays set. Stalls are safe because cu_out is held.
- DRAIN: performs the pending capture and drives cu_enable = 0. Go to BIAS.
- BIAS: drive cu_enable = 1, cu_sel = 00, cu_data = acc, cu_par = bias. Go to CMP.
- CMP: drive cu_enable = 1, cu_sel = 01, cu_data = cu_out, cu_par = threshold, and out_result <= cu_out. Go to DONE.
- DONE: out_flag <= cu_out[0] on entry; out_valid = 1; outputs held stable until out_ready = 1. Go to IDLE on the handshake edge. out_valid drops the cycle after the handshake.
- Arithmetic: all results are mod 2^DW (CU truncation). Products are low DW bits. The compare is unsigned.
- Latency without stalls: start sampled at edge 0 -> out_valid high in cycle 2N+4. For N = 0 this is cycle 4, and out_result = 0 - bias.
- Each in_valid stall cycle adds exactly one cycle of latency. out_ready backpressure holds DONE indefinitely.

Test Plan:
- len=3, pairs (1,4),(2,5),(3,6) with in_valid held high, bias=10, threshold=20 -> out_valid in cycle 10, out_result=22, out_flag=1; cu_sel sequence 11,10,11,10,11,10,-,00,01.
- Same job with threshold=22 -> out_result=22, out_flag=0 (strict greater-than).
- len=0, bias=5, threshold=0 -> out_valid in cycle 4, out_result=0xFFFFFFFB, out_flag=1; in_ready never asserts.
- len=2, pairs (0x10000,0x10000),(3,3), in_valid low for 3 cycles before the second pair, bias=0 -> out_result=9 (product wraps to 0), out_valid delayed by exactly 3 cycles, acc intact.
- out_ready held low 5 cycles in DONE, with start pulsed meanwhile -> outputs stable, start ignored; after the handshake, busy=0 and the next start is accepted.
- rst_n pulled low mid-ADD of a len=4 job -> all outputs go to reset values asynchronously; a new start after release runs a clean job with acc starting at 0.
